// File: rtl/req_fifo_stage.sv
// Three-channel request buffer feeding a round-robin arbiter: per-channel FIFOs raise req,
// the arbiter's one-hot gnt pops the granted head into a single registered valid/ready port.
module req_fifo_stage #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      in_valid,
  input  logic [3*DW-1:0] in_data,
  output logic [2:0]      in_ready,
  output logic [2:0]      req,
  input  logic [2:0]      gnt,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_src,
  input  logic            out_ready,
  output logic            gnt_err
);

  localparam int NCH = 3;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // True when two or more grant bits are set.
  function automatic logic multi_hot(input logic [2:0] g);
    return (g[0] & g[1]) | (g[0] & g[2]) | (g[1] & g[2]);
  endfunction

  logic [DW-1:0] mem_q    [NCH][DEPTH];
  logic [DW-1:0] mem_d    [NCH][DEPTH];
  logic [AW-1:0] wr_ptr_q [NCH];
  logic [AW-1:0] wr_ptr_d [NCH];
  logic [AW-1:0] rd_ptr_q [NCH];
  logic [AW-1:0] rd_ptr_d [NCH];
  logic [CW-1:0] cnt_q    [NCH];
  logic [CW-1:0] cnt_d    [NCH];

  logic          out_valid_q;
  logic          out_valid_d;
  logic [DW-1:0] out_data_q;
  logic [DW-1:0] out_data_d;
  logic [1:0]    out_src_q;
  logic [1:0]    out_src_d;
  logic          gnt_err_q;
  logic          gnt_err_d;

  logic [2:0]    full_s;
  logic [2:0]    empty_s;
  logic [2:0]    push_s;
  logic [2:0]    pop_s;
  logic          slot_free_s;
  logic          gnt_multi_s;

  // Channel status and push/pop qualification, all from registered state plus this cycle's inputs.
  always_comb begin
    gnt_multi_s = multi_hot(gnt);
    slot_free_s = !out_valid_q || out_ready;
    full_s      = 3'b000;
    empty_s     = 3'b000;
    push_s      = 3'b000;
    pop_s       = 3'b000;
    for (int i = 0; i < NCH; i++) begin
      full_s[i]  = (cnt_q[i] == FULL_CNT);
      empty_s[i] = (cnt_q[i] == {CW{1'b0}});
      // A full channel refuses a push even when it is popped in the same cycle.
      push_s[i]  = in_valid[i] && !full_s[i];
      pop_s[i]   = gnt[i] && !empty_s[i] && slot_free_s && !gnt_multi_s;
    end
  end

  // FIFO storage, pointer and occupancy updates.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NCH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (push_s[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data[i*DW +: DW];
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_ONE;
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Output register: load the popped head, otherwise drain on out_ready and hold payload.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    case (pop_s)
      3'b001: begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[0][rd_ptr_q[0]];
        out_src_d   = 2'd0;
      end
      3'b010: begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[1][rd_ptr_q[1]];
        out_src_d   = 2'd1;
      end
      3'b100: begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[2][rd_ptr_q[2]];
        out_src_d   = 2'd2;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
    endcase
  end

  // Sticky illegal-grant flag.
  always_comb begin
    gnt_err_d = gnt_err_q | gnt_multi_s;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= {AW{1'b0}};
        rd_ptr_q[i] <= {AW{1'b0}};
        cnt_q[i]    <= {CW{1'b0}};
      end
      out_valid_q <= 1'b0;
      out_data_q  <= {DW{1'b0}};
      out_src_q   <= 2'd0;
      gnt_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      gnt_err_q   <= gnt_err_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = ~full_s;
  assign req       = ~empty_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign gnt_err   = gnt_err_q;

endmodule
